// File: rtl/rej_uniform_sampler.sv
`default_nettype none
// ============================================================================
// Module   : rej_uniform_sampler
// Purpose  : Rejection sampler for Kyber matrix generation (SampleNTT/Parse).
//            Consumes SHAKE128 squeeze blocks and emits N coefficients that
//            are uniform in [0, Q-1]. A further block is requested whenever
//            one block runs out before N coefficients have been accepted.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            enable            - start pulse, honoured only while idle
//            state_in          - 1600-bit Keccak state, byte i = [8i+7:8i]
//            state_valid       - state_in holds a fresh block (waiting only)
//            state_req         - one-cycle pulse, next block needed
//            coeff_out/idx     - accepted coefficient and its index
//            coeff_valid       - coefficient strobe (no backpressure)
//            busy              - high in every state except idle
//            done              - one-cycle pulse with the last coefficient
// Revision : 1.0 - initial release
// ============================================================================
module rej_uniform_sampler #(
    parameter int RATE_BYTES = 168,
    parameter int Q          = 3329,
    parameter int N          = 256
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    input  logic [1599:0] state_in,
    input  logic          state_valid,
    output logic          state_req,
    output logic [11:0]   coeff_out,
    output logic [7:0]    coeff_idx,
    output logic          coeff_valid,
    output logic          busy,
    output logic          done
);

    localparam int                  c_RATE_BITS = 8 * RATE_BYTES;
    localparam int                  c_NCAND     = 2 * RATE_BYTES / 3;
    localparam int                  c_CAND_W    = $clog2(c_NCAND);
    localparam logic [c_CAND_W-1:0] c_LAST_CAND = c_CAND_W'(c_NCAND - 1);
    localparam logic [11:0]         c_Q         = 12'(Q);
    localparam logic [7:0]          c_LAST_IDX  = 8'(N - 1);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_WAIT_BLK = 2'd1;
    localparam logic [1:0] S_SAMPLE   = 2'd2;

    logic [1:0]             r_state;
    logic [1:0]             w_next_state;
    logic [c_RATE_BITS-1:0] r_buf;
    logic [c_CAND_W-1:0]    r_cand;
    logic [7:0]             r_count;
    logic                   r_state_req;
    logic                   r_coeff_valid;
    logic                   r_done;
    logic [11:0]            r_coeff_out;
    logic [7:0]             r_coeff_idx;

    logic [11:0] w_d;
    logic        w_sampling;
    logic        w_accept;
    logic        w_final;
    logic        w_last_cand;
    logic        w_start;
    logic        w_load;
    logic        w_req;

    // Only the rate portion of the Keccak state is ever consumed.
    generate
        if (c_RATE_BITS < 1600) begin : g_unused_state
            logic w_unused_state;
            assign w_unused_state = ^state_in[1599:c_RATE_BITS];
        end
    endgenerate

    // The buffer is shifted down one triple after every odd candidate, so the
    // current triple always sits in the low 24 bits and no wide mux is needed.
    assign w_d         = r_cand[0] ? {r_buf[23:16], r_buf[15:12]}
                                   : {r_buf[11:8],  r_buf[7:0]};
    assign w_sampling  = (r_state == S_SAMPLE);
    assign w_accept    = w_sampling && (w_d < c_Q);
    assign w_final     = w_accept && (r_count == c_LAST_IDX);
    assign w_last_cand = (r_cand == c_LAST_CAND);
    assign w_start     = (r_state == S_IDLE) && enable;
    assign w_load      = (r_state == S_WAIT_BLK) && state_valid;
    // Finishing on the very last candidate of a block must not ask for more.
    assign w_req       = w_start || (w_sampling && w_last_cand && !w_final);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (enable) begin
                    w_next_state = S_WAIT_BLK;
                end
            end
            S_WAIT_BLK: begin
                if (state_valid) begin
                    w_next_state = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                if (w_final) begin
                    w_next_state = S_IDLE;
                end else if (w_last_cand) begin
                    w_next_state = S_WAIT_BLK;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_req   <= 1'b0;
            r_coeff_valid <= 1'b0;
            r_done        <= 1'b0;
            r_coeff_out   <= 12'd0;
            r_coeff_idx   <= 8'd0;
            r_count       <= 8'd0;
            r_cand        <= '0;
        end else begin
            r_state_req   <= w_req;
            r_coeff_valid <= w_accept;
            r_done        <= w_final;
            if (w_start) begin
                r_count <= 8'd0;
            end else if (w_accept) begin
                r_count <= r_count + 8'd1;
            end
            // coeff_out/coeff_idx hold their values between accepted samples.
            if (w_accept) begin
                r_coeff_out <= w_d;
                r_coeff_idx <= r_count;
            end
            if (w_load) begin
                r_cand <= '0;
            end else if (w_sampling) begin
                r_cand <= r_cand + 1'b1;
            end
        end
    end

    // Block buffer contents are irrelevant outside a block, so it is not reset.
    always_ff @(posedge clk) begin
        if (w_load) begin
            r_buf <= state_in[c_RATE_BITS-1:0];
        end else if (w_sampling && r_cand[0]) begin
            r_buf <= r_buf >> 24;
        end
    end

    assign state_req   = r_state_req;
    assign coeff_out   = r_coeff_out;
    assign coeff_idx   = r_coeff_idx;
    assign coeff_valid = r_coeff_valid;
    assign done        = r_done;
    assign busy        = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_rej_uniform_sampler.sv
`default_nettype none
// ============================================================================
// Module   : tb_rej_uniform_sampler
// Purpose  : Self-checking bench for rej_uniform_sampler. A byte-level
//            reference sampler predicts the coefficient stream; a monitor
//            compares every strobe against it, and directed scenarios pin
//            timing, boundary values, reset and ignored inputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rej_uniform_sampler;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic [1599:0] state_in;
    logic          state_valid;
    logic          state_req;
    logic [11:0]   coeff_out;
    logic [7:0]    coeff_idx;
    logic          coeff_valid;
    logic          busy;
    logic          done;

    rej_uniform_sampler #(.RATE_BYTES(168), .Q(3329), .N(256)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .state_in   (state_in),
        .state_valid(state_valid),
        .state_req  (state_req),
        .coeff_out  (coeff_out),
        .coeff_idx  (coeff_idx),
        .coeff_valid(coeff_valid),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int              errors = 0;
    int              checks = 0;
    logic [1343:0]   blk_q[$];
    int              exp_q[$];
    int              exp_arr[256];
    int              model_nb;
    int              got[256];
    int              got_cnt;
    int              exp_idx;
    int              req_cnt;
    int              done_cnt;
    int              first_valid_cyc;
    int              en_cyc;
    int              req_cycs[8];
    int              sv_cycs[8];

    function automatic void chk(string name, longint act, longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    // Reference sampler: walks the byte stream triple by triple, two
    // 12-bit candidates per triple, keeping those below 3329 until 256.
    function automatic void build_model();
        int acc;
        int b0, b1, b2;
        int d[2];
        acc      = 0;
        model_nb = 0;
        exp_q.delete();
        for (int b = 0; b < blk_q.size() && acc < 256; b++) begin
            model_nb++;
            for (int t = 0; t < 56; t++) begin
                b0 = int'(blk_q[b][24*t +: 8]);
                b1 = int'(blk_q[b][24*t+8 +: 8]);
                b2 = int'(blk_q[b][24*t+16 +: 8]);
                d[0] = b0 + 256 * (b1 % 16);
                d[1] = b1 / 16 + 16 * b2;
                for (int k = 0; k < 2; k++) begin
                    if (acc < 256 && d[k] < 3329) begin
                        exp_q.push_back(d[k]);
                        exp_arr[acc] = d[k];
                        acc++;
                    end
                end
            end
        end
    endfunction

    function automatic logic [1599:0] rand_state();
        logic [1599:0] v;
        for (int i = 0; i < 50; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    // Per-cycle compare against the model stream.
    always @(negedge clk) begin
        int e;
        if (coeff_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_coeff_valid", coeff_idx, -1);
            end else begin
                e = exp_q.pop_front();
                chk("coeff_out", coeff_out, e);
                chk("coeff_idx", coeff_idx, exp_idx);
                chk("coeff_range", coeff_out < 12'd3329, 1);
                chk("done_with_idx", done, exp_idx == 255);
                if (got_cnt < 256) got[got_cnt] = coeff_out;
                got_cnt++;
                exp_idx++;
            end
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
        end else if (done) begin
            chk("done_without_valid", done, 0);
        end
        if (state_req) begin
            if (req_cnt < 8) req_cycs[req_cnt] = cyc;
            req_cnt++;
        end
        if (done) begin
            done_cnt++;
            chk("busy_in_done", busy, 0);
        end
    end

    task automatic clear_stats();
        got_cnt         = 0;
        exp_idx         = 0;
        req_cnt         = 0;
        done_cnt        = 0;
        first_valid_cyc = -1;
    endtask

    task automatic wait_req(input int n);
        int k = 0;
        while (req_cnt < n && k < 400) begin
            @(negedge clk); #1;
            k++;
        end
        if (req_cnt < n) chk("state_req_timeout", req_cnt, n);
    endtask

    task automatic start_run();
        @(posedge clk); #1;
        enable = 1'b1;
        en_cyc = cyc;
        @(posedge clk); #1;
        enable = 1'b0;
    endtask

    task automatic feed_block(input int b, input int gap, input bit disturb);
        repeat (gap) begin
            @(posedge clk); #1;
            enable = disturb;
        end
        @(posedge clk); #1;
        enable      = 1'b0;
        state_in    = rand_state();
        state_in[1343:0] = blk_q[b];
        state_valid = 1'b1;
        if (b < 8) sv_cycs[b] = cyc;
        @(posedge clk); #1;
        state_valid = 1'b0;
        state_in    = rand_state();
        if (disturb) begin
            repeat (5) @(posedge clk);
            #1;
            enable      = 1'b1;
            state_valid = 1'b1;
            state_in    = '1;
            @(posedge clk); #1;
            enable      = 1'b0;
            state_valid = 1'b0;
        end
    endtask

    task automatic run(input int gap, input bit disturb);
        int k;
        build_model();
        clear_stats();
        start_run();
        for (int b = 0; b < model_nb; b++) begin
            wait_req(b + 1);
            feed_block(b, gap, disturb);
        end
        k = 0;
        while (done_cnt < 1 && k < 400) begin
            @(negedge clk); #1;
            k++;
        end
        repeat (3) @(negedge clk);
        #1;
        chk("exp_queue_drained", exp_q.size(), 0);
        chk("coeff_count", got_cnt, 256);
        chk("req_count", req_cnt, model_nb);
        chk("done_count", done_cnt, 1);
        chk("busy_after_done", busy, 0);
    endtask

    initial begin
        logic [1343:0] blk;
        int k;
        rst         = 1'b1;
        enable      = 1'b0;
        state_valid = 1'b0;
        state_in    = '0;
        clear_stats();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_coeff_valid", coeff_valid, 0);
        chk("reset_state_req", state_req, 0);
        chk("reset_coeff_out", coeff_out, 0);
        chk("reset_coeff_idx", coeff_idx, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // All-zero blocks: 112 + 112 + 32 coefficients of value 0.
        blk_q.delete();
        repeat (5) blk_q.push_back('0);
        run(1, 1'b0);
        chk("t1_model_blocks", model_nb, 3);
        chk("t1_req_after_enable", req_cycs[0] - en_cyc, 1);
        chk("t1_first_latency", first_valid_cyc - sv_cycs[0], 2);
        chk("t1_req_after_block", req_cycs[1] - sv_cycs[0], 113);
        chk("t1_last_coeff", got[255], 0);

        // All-0xFF first block: every candidate is 4095 and rejected.
        blk_q.delete();
        blk_q.push_back('1);
        repeat (4) blk_q.push_back('0);
        run(2, 1'b0);
        chk("t2_model_blocks", model_nb, 4);
        chk("t2_req_after_cand111", req_cycs[1] - sv_cycs[0], 113);
        chk("t2_no_valid_in_ff_block", first_valid_cyc > req_cycs[1], 1);

        // Boundary candidates 3328, 0, 3329 (rejected), 208.
        blk = '0;
        blk[47:0] = {8'h0D, 8'h0D, 8'h01, 8'h00, 8'h0D, 8'h00};
        blk_q.delete();
        blk_q.push_back(blk);
        repeat (3) blk_q.push_back('0);
        run(0, 1'b0);
        chk("t3_model_d0", exp_arr[0], 3328);
        chk("t3_model_d1", exp_arr[1], 0);
        chk("t3_model_d3", exp_arr[2], 208);
        chk("t3_coeff0", got[0], 3328);
        chk("t3_coeff1", got[1], 0);
        chk("t3_coeff2", got[2], 208);
        chk("t3_model_blocks", model_nb, 3);

        // Pseudo-random squeeze output.
        blk_q.delete();
        for (int i = 0; i < 6; i++) begin
            state_in = rand_state();
            blk      = state_in[1343:0];
            blk_q.push_back(blk);
        end
        run(1, 1'b0);

        // Reset right after idx 100 is seen.
        blk_q.delete();
        repeat (3) blk_q.push_back('0);
        build_model();
        clear_stats();
        start_run();
        wait_req(1);
        feed_block(0, 0, 1'b0);
        k = 0;
        while (got_cnt < 101 && k < 400) begin
            @(negedge clk); #1;
            k++;
        end
        chk("t5_reached_idx100", got_cnt, 101);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        chk("t5_busy_after_rst", busy, 0);
        chk("t5_valid_after_rst", coeff_valid, 0);
        chk("t5_done_after_rst", done, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (20) @(negedge clk);
        #1;
        chk("t5_no_more_coeffs", got_cnt, 101);
        chk("t5_no_more_reqs", req_cnt, 1);
        chk("t5_no_done", done_cnt, 0);
        run(1, 1'b0);

        // Enable while busy and state_valid during sampling are ignored.
        blk_q.delete();
        repeat (5) blk_q.push_back('0);
        run(2, 1'b1);
        chk("t6_last_coeff", got[255], 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
